// File: rtl/bcd_seg7_scan_pkg.sv
// ============================================================================
// Module : bcd_seg7_scan_pkg
// Brief  : Shared glyph/anode constants and types for the two-digit
//          multiplexed seven-segment scanner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bcd_seg7_scan_pkg;

    // Glyphs are {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Anodes are active low: bit 0 drives the ones digit, bit 1 the tens.
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } digit_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    localparam bcd_pair_t PAIR_ZERO = '{tens: 4'd0, ones: 4'd0};

endpackage : bcd_seg7_scan_pkg

`default_nettype wire

// File: rtl/bcd_seg7_scan_bcd_to_seg7.sv
// ============================================================================
// Module : bcd_to_seg7
// Brief  : Combinational BCD to active-low seven-segment decoder; codes
//          10..15 render as a dash.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_to_seg7
    import bcd_seg7_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7

`default_nettype wire

// File: rtl/bcd_seg7_scan.sv
// ============================================================================
// Module : bcd_seg7_scan
// Brief  : Two-digit multiplexed seven-segment driver with a shadow register
//          that commits only on frame boundaries.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_seg7_scan
    import bcd_seg7_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int              CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tick;
    digit_e        r_idx;
    logic          w_frame_end;
    bcd_pair_t     w_incoming;
    bcd_pair_t     r_shadow;
    bcd_pair_t     r_disp;
    logic          r_pending;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic [1:0]    w_an;
    logic [1:0]    r_an;
    logic [6:0]    r_seg;

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    assign w_tick      = (r_cnt == C_LAST);
    assign w_frame_end = w_tick && (r_idx == DIG_TENS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= DIG_ONES;
        end else if (w_tick) begin
            r_idx <= (r_idx == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    // ------------------------------------------------------------------
    // Shadow / display registers. A load landing on the frame-end cycle
    // goes straight to the display so it is not held for a whole frame.
    // ------------------------------------------------------------------
    assign w_incoming = '{tens: tens, ones: ones};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= PAIR_ZERO;
            r_disp    <= PAIR_ZERO;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= w_incoming;
            end

            if (load && w_frame_end) begin
                r_disp    <= w_incoming;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end else if (w_frame_end && r_pending) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit select, decode and output registers
    // ------------------------------------------------------------------
    assign w_digit = (r_idx == DIG_TENS) ? r_disp.tens : r_disp.ones;

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_comb begin
        w_an = AN_ONES;
        if (r_idx == DIG_TENS) begin
            // Blanking only darkens the anode; the cathodes keep the glyph.
            if (blank_lz && (r_disp.tens == 4'd0)) begin
                w_an = AN_OFF;
            end else begin
                w_an = AN_TENS;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule : bcd_seg7_scan

`default_nettype wire
